// File: rtl/down_counter_modulo_n.sv
// ---------------------------------------------------------------------------
// down_counter_modulo_n
//
// Loadable modulo-N down-counter / timer. Counts N-1 down to 0 while enabled.
// On the edge that consumes count 0 it emits a one-cycle terminal_count pulse
// and then either reloads N-1 (auto_reload = 1) or parks at 0 in the EXPIRED
// state (auto_reload = 0) until the next load.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset (count = N-1, state RUN)
//   enable         count enable, decrement on each rising edge when high
//   load           synchronous load strobe, priority over enable
//   load_value     value loaded on load, clamped to N-1
//   auto_reload    1: wrap 0 -> N-1, 0: one-shot, stop at 0
//   counter_out    current count (registered)
//   terminal_count registered one-cycle pulse on each 0-crossing
//   expired        high while the one-shot has finished (EXPIRED state)
// ---------------------------------------------------------------------------
module down_counter_modulo_n #(
    parameter int CNT_WIDTH = 4,
    parameter int N         = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 auto_reload,
    output logic [CNT_WIDTH-1:0] counter_out,
    output logic                 terminal_count,
    output logic                 expired
);

    localparam logic [CNT_WIDTH-1:0] TOP = CNT_WIDTH'(N - 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_EXPIRED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   tc_q, tc_d;
    logic [CNT_WIDTH-1:0]   load_clamped;

    // Out-of-range load values saturate silently at the top of the range.
    assign load_clamped = (load_value > TOP) ? TOP : load_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            count_q <= TOP;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        // The pulse only lives for the cycle after a 0-crossing.
        tc_d    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (load) begin
                    // Load beats a coincident 0-crossing: no pulse, no expiry.
                    count_d = load_clamped;
                end else if (enable) begin
                    if (count_q != '0) begin
                        count_d = count_q - CNT_WIDTH'(1);
                    end else begin
                        tc_d = 1'b1;
                        // auto_reload only matters right here.
                        if (auto_reload) begin
                            count_d = TOP;
                        end else begin
                            state_d = ST_EXPIRED;
                        end
                    end
                end
            end

            ST_EXPIRED: begin
                // Parked at 0; enable and auto_reload are ignored.
                count_d = '0;
                if (load) begin
                    count_d = load_clamped;
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
                count_d = TOP;
            end
        endcase
    end

    assign counter_out    = count_q;
    assign terminal_count = tc_q;
    assign expired        = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_down_counter_modulo_n.sv
module tb_down_counter_modulo_n;

    localparam int CNT_WIDTH = 4;
    localparam int N         = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 load;
    logic [CNT_WIDTH-1:0] load_value;
    logic                 auto_reload;
    logic [CNT_WIDTH-1:0] counter_out;
    logic                 terminal_count;
    logic                 expired;

    int checks = 0;
    int errors = 0;

    // Reference model: integer count, expiry flag, pulse flag.
    int m_cnt;
    bit m_exp;
    bit m_tc;

    down_counter_modulo_n #(.CNT_WIDTH(CNT_WIDTH), .N(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .load           (load),
        .load_value     (load_value),
        .auto_reload    (auto_reload),
        .counter_out    (counter_out),
        .terminal_count (terminal_count),
        .expired        (expired)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v);
        return (v > N - 1) ? N - 1 : v;
    endfunction

    task automatic model_reset();
        m_cnt = N - 1;
        m_exp = 0;
        m_tc  = 0;
    endtask

    // One clock of the timer described in plain terms.
    task automatic model_step(input bit en, input bit ld, input int lv, input bit ar);
        m_tc = 0;
        if (ld) begin
            m_cnt = clamp(lv);
            m_exp = 0;
        end else if (!m_exp && en) begin
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end else begin
                m_tc = 1;
                if (ar) m_cnt = N - 1;
                else    m_exp = 1;
            end
        end
    endtask

    // Drive inputs for one edge, advance to just after it, update the model.
    task automatic tick(input bit en, input bit ld, input int lv, input bit ar);
        enable      = en;
        load        = ld;
        load_value  = CNT_WIDTH'(lv);
        auto_reload = ar;
        @(posedge clk);
        #1;
        model_step(en, ld, lv, ar);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b0; load_value = '0; auto_reload = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({counter_out, terminal_count, expired} !== {CNT_WIDTH'(N - 1), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset cyc=%0d cnt=%0d tc=%0b exp=%0b want cnt=%0d tc=0 exp=0",
                         i, counter_out, terminal_count, expired, N - 1);
            end
        end
        reset = 1'b0;
        $display("reset: cnt=%0d tc=%0b exp=%0b", counter_out, terminal_count, expired);
    endtask

    task automatic test_free_run();
        int pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            int want = ((N - 1 - k) % N + N) % N;
            tick(1, 0, 0, 1);
            if (terminal_count) pulses++;
            checks++;
            if ({counter_out, terminal_count, expired} !== {CNT_WIDTH'(want), (k == N), 1'b0}) begin
                errors++;
                $display("FAIL free_run k=%0d cnt=%0d tc=%0b exp=%0b want cnt=%0d tc=%0b exp=0",
                         k, counter_out, terminal_count, expired, want, (k == N));
            end
            $display("free_run k=%0d cnt=%0d tc=%0b", k, counter_out, terminal_count);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL free_run_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_one_shot();
        int pulses = 0;
        tick(0, 1, N - 1, 0);
        for (int k = 1; k <= 14; k++) begin
            tick(1, 0, 0, 0);
            if (terminal_count) pulses++;
            checks++;
            if ({counter_out, terminal_count, expired} !==
                {CNT_WIDTH'(m_cnt), m_tc, m_exp} ||
                (k >= N && expired !== 1'b1) || (k < N && counter_out !== CNT_WIDTH'(N - 1 - k))) begin
                errors++;
                $display("FAIL one_shot k=%0d cnt=%0d tc=%0b exp=%0b want cnt=%0d tc=%0b exp=%0b",
                         k, counter_out, terminal_count, expired, m_cnt, m_tc, m_exp);
            end
            $display("one_shot k=%0d cnt=%0d tc=%0b exp=%0b", k, counter_out, terminal_count, expired);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL one_shot_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_load_clamp();
        // Starts in EXPIRED from the one-shot test.
        int lvs[4] = '{5, -1, -1, 12};
        bit lds[4] = '{1, 0, 0, 1};
        int wants[4] = '{5, 4, 3, 9};
        for (int i = 0; i < 4; i++) begin
            tick(!lds[i], lds[i], (lvs[i] < 0) ? 0 : lvs[i], 0);
            checks++;
            if ({counter_out, terminal_count, expired} !== {CNT_WIDTH'(wants[i]), 1'b0, 1'b0} ||
                counter_out !== CNT_WIDTH'(m_cnt)) begin
                errors++;
                $display("FAIL load_clamp step=%0d cnt=%0d tc=%0b exp=%0b want cnt=%0d tc=0 exp=0",
                         i, counter_out, terminal_count, expired, wants[i]);
            end
            $display("load_clamp step=%0d cnt=%0d exp=%0b", i, counter_out, expired);
        end
    endtask

    task automatic test_enable_gating();
        tick(0, 1, 6, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1);
            checks++;
            if ({counter_out, terminal_count} !== {CNT_WIDTH'(6), 1'b0}) begin
                errors++;
                $display("FAIL enable_gating hold=%0d cnt=%0d tc=%0b want cnt=6 tc=0",
                         i, counter_out, terminal_count);
            end
        end
        tick(1, 0, 0, 1);
        checks++;
        if (counter_out !== CNT_WIDTH'(5)) begin
            errors++;
            $display("FAIL enable_gating resume cnt=%0d want=5", counter_out);
        end
        $display("enable_gating cnt=%0d", counter_out);
    endtask

    task automatic test_simultaneous();
        for (int ar = 0; ar < 2; ar++) begin
            tick(0, 1, 0, ar[0]);
            tick(1, 1, 3, ar[0]);
            checks++;
            if ({counter_out, terminal_count, expired} !== {CNT_WIDTH'(3), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL simultaneous ar=%0d cnt=%0d tc=%0b exp=%0b want cnt=3 tc=0 exp=0",
                         ar, counter_out, terminal_count, expired);
            end
            $display("simultaneous ar=%0d cnt=%0d tc=%0b exp=%0b", ar, counter_out, terminal_count, expired);
        end
    endtask

    task automatic test_async_reset();
        // Mid-count reset.
        tick(0, 1, 4, 1);
        #3 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({counter_out, terminal_count, expired} !== {CNT_WIDTH'(N - 1), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_mid cnt=%0d tc=%0b exp=%0b want cnt=%0d tc=0 exp=0",
                     counter_out, terminal_count, expired, N - 1);
        end
        enable = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (counter_out !== CNT_WIDTH'(N - 1)) begin
            errors++;
            $display("FAIL async_reset_hold cnt=%0d want=%0d", counter_out, N - 1);
        end
        reset = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick(1, 0, 0, 1);
            checks++;
            if (counter_out !== CNT_WIDTH'(N - 1 - k)) begin
                errors++;
                $display("FAIL async_reset_resume k=%0d cnt=%0d want=%0d", k, counter_out, N - 1 - k);
            end
        end
        // Reset during the terminal_count pulse cuts it.
        tick(0, 1, 0, 1);
        tick(1, 0, 0, 1);
        checks++;
        if (terminal_count !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_pulse_pre tc=%0b want=1", terminal_count);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({counter_out, terminal_count} !== {CNT_WIDTH'(N - 1), 1'b0}) begin
            errors++;
            $display("FAIL async_reset_pulse cnt=%0d tc=%0b want cnt=%0d tc=0",
                     counter_out, terminal_count, N - 1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        $display("async_reset cnt=%0d tc=%0b", counter_out, terminal_count);
    endtask

    task automatic test_random();
        bit ar = 1'b1;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            bit en = ($urandom_range(0, 3) != 0);
            bit ld = ($urandom_range(0, 11) == 0);
            int lv = $urandom_range(0, (1 << CNT_WIDTH) - 1);
            if ($urandom_range(0, 15) == 0) ar = ~ar;
            tick(en, ld, lv, ar);
            checks++;
            if ({counter_out, terminal_count, expired} !== {CNT_WIDTH'(m_cnt), m_tc, m_exp}) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random i=%0d cnt=%0d tc=%0b exp=%0b want cnt=%0d tc=%0b exp=%0b",
                             i, counter_out, terminal_count, expired, m_cnt, m_tc, m_exp);
            end
        end
        $display("random: 400 cycles, last cnt=%0d", counter_out);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_one_shot();
        test_load_clamp();
        test_enable_gating();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/down_counter_modulo_n.md
Name: down_counter_modulo_n

Overview:
Loadable modulo-N down-counter/timer; the count-down counterpart of the team's modulo-N up-counter. Counts N-1 down to 0 while enabled, then either reloads N-1 (auto-reload mode) or stops at 0 and flags expiry (one-shot mode). Drives a one-cycle terminal-count pulse for timeout, baud-tick and watchdog logic in the sequential-design library.

Parameters:
CNT_WIDTH, 4, width of counter_out and load_value; must satisfy 2**CNT_WIDTH >= N
N, 10, modulus; counter range 0..N-1; N >= 2

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
enable  input  1  count enable; decrement on rising clk edge when high
load  input  1  synchronous load strobe; priority over enable
load_value  input  CNT_WIDTH  value loaded on load; clamped to N-1
auto_reload  input  1  1: wrap 0 -> N-1 and keep counting; 0: one-shot, stop at 0
counter_out  output  CNT_WIDTH  current count, registered
terminal_count  output  1  registered one-cycle pulse on each 0-crossing
expired  output  1  high while in EXPIRED state (one-shot finished)

Behaviour:
- Reset is asynchronous and active-high: reset high forces counter_out = N-1, terminal_count = 0, expired = 0 and state = RUN immediately, independent of clk. The block holds these values while reset is high.
- After reset releases, the first active edge is the first rising clk edge with reset low.
- FSM states and transitions:
  - RUN: counting state.
    - load = 1: counter_out <= min(load_value, N-1); stay RUN; terminal_count <= 0.
    - else enable = 1 and counter_out != 0: counter_out <= counter_out - 1.
    - else enable = 1 and counter_out == 0: terminal_count <= 1. If auto_reload = 1, counter_out <= N-1 and stay RUN. If auto_reload = 0, counter_out stays 0 and state goes to EXPIRED.
    - else enable = 0: hold counter_out; terminal_count <= 0.
  - EXPIRED: expired = 1 and counter_out = 0. enable is ignored.
    - load = 1: counter_out <= min(load_value, N-1); go to RUN; expired <= 0.
    - auto_reload has no effect in this state.
- terminal_count is high for exactly one clk cycle after the edge that consumes count 0. It is high again only on the next 0-crossing. It is never high two consecutive cycles unless N... (not possible for N >= 2).
- auto_reload is sampled only at the 0-crossing edge; changing it mid-count has no other effect.
- load coinciding with a 0-crossing: load wins, no terminal_count pulse, no expiry.
- load_value >= N is clamped to N-1. There is no error flag.
- Arithmetic is unsigned, CNT_WIDTH bits. No underflow is possible because 0 is handled explicitly.
- Latency: load and decrement are visible on counter_out one edge after they are sampled. expired rises on the same edge that terminal_count pulses.
- Reset asserted mid-count or mid-pulse: takes effect immediately, the pulse is cut, and the block returns to RUN at N-1.

Test Plan:
- Free run (N=10, auto_reload=1): release reset, enable=1 for 12 edges -> counter_out 9,8,...,0,9,8; terminal_count high only during the cycle counter_out first shows 9 after 0; expired stays 0.
- One-shot (auto_reload=0): enable=1 for 14 edges -> 9..0, then holds 0. terminal_count pulses once; expired=1 from the same edge onward; further enable causes no change.
- Load and clamp: in EXPIRED, load=1, load_value=5 -> counter_out=5, expired=0, then 4,3 with enable. Next, load_value=12 -> counter_out=9.
- Enable gating: at count 6, drop enable for 3 cycles -> counter_out holds 6, no terminal_count; on re-enable, counting resumes at 5.
- Simultaneous: counter_out=0, enable=1, load=1, load_value=3 -> counter_out=3, terminal_count=0, expired=0.
- Async reset mid-count: at count 4, assert reset between clk edges -> counter_out=9 and terminal_count=0 before the next edge. After release, counting resumes 8,7.
